// File: rtl/game_pkg.sv
// Shared types for the bullet engine: slot record, owner and sweep FSM encodings.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package game_pkg;

    localparam int DEFAULT_GRID_W = 80;
    localparam int DEFAULT_GRID_H = 60;
    localparam int BULLET_POS_W   = 7;
    localparam int BULLET_VEL_W   = 3;

    typedef enum logic {
        OWNER_PLAYER = 1'b0,
        OWNER_ENEMY  = 1'b1
    } owner_e;

    typedef struct packed {
        logic                           active;
        owner_e                         owner;
        logic [BULLET_POS_W-1:0]        x;
        logic [BULLET_POS_W-1:0]        y;
        logic signed [BULLET_VEL_W-1:0] dx;
        logic signed [BULLET_VEL_W-1:0] dy;
    } bullet_t;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } pool_state_e;

    // Unsigned distance between two on-grid coordinates.
    function automatic logic [BULLET_POS_W-1:0] absDiff(input logic [BULLET_POS_W-1:0] a,
                                                        input logic [BULLET_POS_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/bullet_step.sv
// One-frame update of a single bullet record: move, cull off-grid, detect ship hits.
// Latency: purely combinational.
// Backpressure: none; evaluated for whichever slot the sweep is pointing at.
module bullet_step
    import game_pkg::*;
#(
    parameter int GRID_W     = DEFAULT_GRID_W,
    parameter int GRID_H     = DEFAULT_GRID_H,
    parameter int HIT_RADIUS = 1
) (
    input  bullet_t                 cur,
    input  logic [BULLET_POS_W-1:0] player_x,
    input  logic [BULLET_POS_W-1:0] player_y,
    input  logic [BULLET_POS_W-1:0] enemy_x,
    input  logic [BULLET_POS_W-1:0] enemy_y,
    output bullet_t                 nxt,
    output logic                    hit_player,  // player ship struck by an enemy bullet
    output logic                    hit_enemy    // enemy ship struck by a player bullet
);

    // One extra bit so positions just past either edge stay representable as signed.
    localparam int SW = BULLET_POS_W + 1;

    logic signed [SW-1:0]    nx;
    logic signed [SW-1:0]    ny;
    logic                    inBounds;
    logic [BULLET_POS_W-1:0] targetX;
    logic [BULLET_POS_W-1:0] targetY;
    logic                    onTarget;

    assign nx = $signed({1'b0, cur.x}) + $signed({{(SW-BULLET_VEL_W){cur.dx[BULLET_VEL_W-1]}}, cur.dx});
    assign ny = $signed({1'b0, cur.y}) + $signed({{(SW-BULLET_VEL_W){cur.dy[BULLET_VEL_W-1]}}, cur.dy});

    assign inBounds = !nx[SW-1] && (nx < SW'(GRID_W)) && !ny[SW-1] && (ny < SW'(GRID_H));

    // A bullet only ever damages the opposing ship.
    assign targetX  = (cur.owner == OWNER_PLAYER) ? enemy_x : player_x;
    assign targetY  = (cur.owner == OWNER_PLAYER) ? enemy_y : player_y;
    assign onTarget = (absDiff(nx[BULLET_POS_W-1:0], targetX) <= BULLET_POS_W'(HIT_RADIUS)) &&
                      (absDiff(ny[BULLET_POS_W-1:0], targetY) <= BULLET_POS_W'(HIT_RADIUS));

    // Culling takes precedence over hits; inactive records pass through unchanged.
    always_comb begin
        nxt        = cur;
        hit_player = 1'b0;
        hit_enemy  = 1'b0;
        if (cur.active) begin
            if (!inBounds) begin
                nxt.active = 1'b0;
            end else if (onTarget) begin
                nxt.active = 1'b0;
                if (cur.owner == OWNER_PLAYER) begin
                    hit_enemy = 1'b1;
                end else begin
                    hit_player = 1'b1;
                end
            end else begin
                nxt.x = nx[BULLET_POS_W-1:0];
                nxt.y = ny[BULLET_POS_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bullet_pool.sv
// Fixed pool of bullet records swept one slot per clock after frame_tick; owns movement, culling, hits, HP. Optional BULLET_POOL_STATS_EN adds hit counters.
// Latency: frame_tick to frame_done is SLOTS+1 cycles; read port is one registered cycle.
// Backpressure: spawn_ready drops while sweeping, when the pool is full, when run is low or on clear; spawner holds valid.
module bullet_pool
    import game_pkg::*;
#(
    parameter int SLOTS      = 32,
    parameter int GRID_W     = DEFAULT_GRID_W,
    parameter int GRID_H     = DEFAULT_GRID_H,
    parameter int POS_W      = BULLET_POS_W,   // must match the bullet_t coordinate width
    parameter int VEL_W      = BULLET_VEL_W,   // must match the bullet_t velocity width
    parameter int HP_W       = 21,
    parameter int PLAYER_DMG = 10,
    parameter int ENEMY_DMG  = 5,
    parameter int HIT_RADIUS = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run,
    input  logic                      frame_tick,
    input  logic                      clear,
    input  logic                      hp_load,
    input  logic [HP_W-1:0]           player_hp_init,
    input  logic [HP_W-1:0]           enemy_hp_init,
    input  logic                      spawn_valid,
    output logic                      spawn_ready,
    input  logic                      spawn_owner,
    input  logic [POS_W-1:0]          spawn_x,
    input  logic [POS_W-1:0]          spawn_y,
    input  logic signed [VEL_W-1:0]   spawn_dx,
    input  logic signed [VEL_W-1:0]   spawn_dy,
    input  logic [POS_W-1:0]          player_x,
    input  logic [POS_W-1:0]          player_y,
    input  logic [POS_W-1:0]          enemy_x,
    input  logic [POS_W-1:0]          enemy_y,
    input  logic [$clog2(SLOTS)-1:0]  rd_idx,
    output logic                      rd_active,
    output logic                      rd_owner,
    output logic [POS_W-1:0]          rd_x,
    output logic [POS_W-1:0]          rd_y,
    output logic [HP_W-1:0]           player_hp,
    output logic [HP_W-1:0]           enemy_hp,
    output logic                      player_dead,
    output logic                      enemy_dead,
    output logic [$clog2(SLOTS):0]    live_count,
    output logic                      busy,
    output logic                      frame_done,
`ifdef BULLET_POOL_STATS_EN
    output logic [15:0]               player_hits,
    output logic [15:0]               enemy_hits,
`endif
    output logic                      overrun
);

    localparam int IDX_W = $clog2(SLOTS);
    localparam int CNT_W = IDX_W + 1;

    bullet_t            pool [SLOTS];
    pool_state_e        state;
    pool_state_e        nextState;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   nextIdx;
    bullet_t            stepIn;
    bullet_t            stepOut;
    logic               hitPlayer;
    logic               hitEnemy;
    logic               sweepStep;
    logic               hitPlayerFire;
    logic               hitEnemyFire;
    logic               hasFree;
    logic [IDX_W-1:0]   freeIdx;
    logic               spawnFire;

    assign stepIn = pool[idx];

    bullet_step #(
        .GRID_W     (GRID_W),
        .GRID_H     (GRID_H),
        .HIT_RADIUS (HIT_RADIUS)
    ) uStep (
        .cur        (stepIn),
        .player_x   (player_x),
        .player_y   (player_y),
        .enemy_x    (enemy_x),
        .enemy_y    (enemy_y),
        .nxt        (stepOut),
        .hit_player (hitPlayer),
        .hit_enemy  (hitEnemy)
    );

    // A clear on the same cycle discards whatever the sweep would have done.
    assign sweepStep     = (state == SWEEP) && !clear;
    assign hitPlayerFire = sweepStep && hitPlayer;
    assign hitEnemyFire  = sweepStep && hitEnemy;

    assign spawn_ready = rst_n && (state == IDLE) && run && hasFree && !clear;
    assign spawnFire   = spawn_valid && spawn_ready;
    assign busy        = (state != IDLE);
    assign frame_done  = (state == DONE);
    assign player_dead = (player_hp == '0);
    assign enemy_dead  = (enemy_hp == '0);

    // Lowest-index inactive slot receives the next spawn.
    always_comb begin
        hasFree = 1'b0;
        freeIdx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!pool[i].active) begin
                hasFree = 1'b1;
                freeIdx = IDX_W'(i);
            end
        end
    end

    // Sweep sequencing: one slot per cycle, then a single DONE cycle.
    always_comb begin
        nextState = state;
        nextIdx   = idx;
        case (state)
            IDLE: begin
                if (frame_tick && run) begin
                    nextState = SWEEP;
                    nextIdx   = '0;
                end
            end
            SWEEP: begin
                nextIdx = idx + IDX_W'(1);
                if (idx == IDX_W'(SLOTS - 1)) begin
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (clear) begin
            nextState = IDLE;
        end
    end

    // FSM state and sweep pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= nextState;
            idx   <= nextIdx;
        end
    end

    // Slot storage: sweep write-back and spawns never coincide (spawns only in IDLE).
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            for (int i = 0; i < SLOTS; i++) begin
                pool[i] <= '0;
            end
        end else if (sweepStep) begin
            pool[idx] <= stepOut;
        end else if (spawnFire) begin
            pool[freeIdx] <= '{active: 1'b1, owner: owner_e'(spawn_owner),
                               x: spawn_x, y: spawn_y, dx: spawn_dx, dy: spawn_dy};
        end
    end

    // Active-slot count tracks spawns and deactivations incrementally.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            live_count <= '0;
        end else if (sweepStep && stepIn.active && !stepOut.active) begin
            live_count <= live_count - CNT_W'(1);
        end else if (spawnFire) begin
            live_count <= live_count + CNT_W'(1);
        end
    end

    // HP bookkeeping: clear freezes HP, a load overrides any same-cycle hit, hits saturate at 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            player_hp <= '0;
            enemy_hp  <= '0;
        end else if (!clear) begin
            if (hp_load) begin
                player_hp <= player_hp_init;
                enemy_hp  <= enemy_hp_init;
            end else begin
                if (hitPlayerFire) begin
                    player_hp <= (player_hp > HP_W'(ENEMY_DMG)) ? player_hp - HP_W'(ENEMY_DMG) : '0;
                end
                if (hitEnemyFire) begin
                    enemy_hp <= (enemy_hp > HP_W'(PLAYER_DMG)) ? enemy_hp - HP_W'(PLAYER_DMG) : '0;
                end
            end
        end
    end

    // Sticky flag for a frame_tick that arrived while a sweep was still running.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            overrun <= 1'b0;
        end else if (frame_tick && run && busy) begin
            overrun <= 1'b1;
        end
    end

    // Registered renderer read port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_active <= 1'b0;
            rd_owner  <= 1'b0;
            rd_x      <= '0;
            rd_y      <= '0;
        end else begin
            rd_active <= pool[rd_idx].active;
            rd_owner  <= pool[rd_idx].owner;
            rd_x      <= pool[rd_idx].x;
            rd_y      <= pool[rd_idx].y;
        end
    end

`ifdef BULLET_POOL_STATS_EN
    // Wrapping hit counters; hp_load zeroes them but a hit on that same cycle still counts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            player_hits <= '0;
            enemy_hits  <= '0;
        end else if (!clear) begin
            player_hits <= (hp_load ? 16'd0 : player_hits) + 16'(hitEnemyFire);
            enemy_hits  <= (hp_load ? 16'd0 : enemy_hits) + 16'(hitPlayerFire);
        end
    end
`else
    // Without the stats build, hits only affect HP and slot state.
`endif

endmodule
